// File: rtl/int_to_fp32_converter.sv
// Multi-cycle 32-bit integer (signed/unsigned) to IEEE-754 single-precision converter.
// Optional `FAST_NORM_EN: normalise by 8 bits per cycle while the top byte is zero.
module int_to_fp32_converter #(
  parameter int BIAS = 127
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [4:0]  r_shcnt;
  logic [31:0] r_result;
  logic        r_inexact;

  logic        w_accept, w_sign;
  logic [31:0] w_mag_in;
  logic [7:0]  w_exp, w_exp_r;
  logic [22:0] w_man, w_man_r;
  logic [23:0] w_man_inc;
  logic        w_guard, w_sticky, w_rup;

  assign w_accept = in_valid & in_ready;
  assign w_sign   = is_signed & int_in[31];
  assign w_mag_in = w_sign ? (~int_in + 32'd1) : int_in;

  // Round to nearest-even; a carry out of the mantissa bumps the exponent.
  assign w_exp     = 8'(BIAS + 31) - {3'b000, r_shcnt};
  assign w_man     = r_mag[30:8];
  assign w_guard   = r_mag[7];
  assign w_sticky  = |r_mag[6:0];
  assign w_rup     = w_guard & (w_sticky | w_man[0]);
  assign w_man_inc = {1'b0, w_man} + 24'd1;
  assign w_man_r   = w_rup ? w_man_inc[22:0] : w_man;
  assign w_exp_r   = w_exp + {7'd0, w_rup & w_man_inc[23]};

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_mag_in == 32'd0) ? S_DONE : S_NORM;
      S_NORM:  if (r_mag[31]) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sign    <= 1'b0;
      r_mag     <= 32'd0;
      r_shcnt   <= 5'd0;
      r_result  <= 32'd0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sign  <= w_sign;
          r_mag   <= w_mag_in;
          r_shcnt <= 5'd0;
          if (w_mag_in == 32'd0) begin
            r_result  <= 32'd0;
            r_inexact <= 1'b0;
          end
        end
        S_NORM: if (!r_mag[31]) begin
`ifdef FAST_NORM_EN
          if (r_mag[31:24] == 8'd0) begin
            r_mag   <= r_mag << 8;
            r_shcnt <= r_shcnt + 5'd8;
          end else begin
            r_mag   <= r_mag << 1;
            r_shcnt <= r_shcnt + 5'd1;
          end
`else
          r_mag   <= r_mag << 1;
          r_shcnt <= r_shcnt + 5'd1;
`endif
        end
        S_ROUND: begin
          r_result  <= {r_sign, w_exp_r, w_man_r};
          r_inexact <= w_guard | w_sticky;
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign inexact = r_inexact;

endmodule

// File: tb/tb_int_to_fp32_converter.sv
// Scoreboard bench for int_to_fp32_converter: arithmetic reference model,
// directed corner cases, randomized operands with random output backpressure.
module tb_int_to_fp32_converter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] int_in = 32'd0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        inexact;

  int_to_fp32_converter #(.BIAS(127)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .int_in(int_in), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .inexact(inexact)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        inex;
    int          lat;   // -1 marks a zero operand
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   seen    = 0;
  int   first   = 0;
  bit   rnd_bp  = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer value rounded to a 24-bit significand, ties to even.
  function automatic logic [32:0] model(input logic [31:0] v, input logic sgn);
    logic    sign;
    longint  m, q, rem, half;
    int      p, e, drop;
    logic    inex;
    sign = sgn & v[31];
    m = sign ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
    if (m == 0) return 33'd0;
    p = 31;
    while (((m >> p) & 1) == 0) p--;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
      inex = 1'b0;
    end else begin
      drop = p - 23;
      q    = m >> drop;
      rem  = m - (q << drop);
      half = longint'(1) << (drop - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
      inex = (rem != 0);
    end
    return {inex, sign, 8'(e), 23'(q)};
  endfunction

  function automatic int exp_latency(input logic [31:0] v, input logic sgn);
    logic [31:0] m;
    int lz;
    m = (sgn & v[31]) ? (~v + 32'd1) : v;
    if (m == 32'd0) return -1;
    lz = 0;
    while (m[31 - lz] == 1'b0) lz++;
`ifdef FAST_NORM_EN
    return lz / 8 + lz % 8 + 2;
`else
    return lz + 2;
`endif
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [31:0] v, input logic s);
    int w;
    exp_t e;
    logic [32:0] m;
    w = 0;
    in_valid = 1'b1; int_in = v; is_signed = s;
    while (!in_ready && w < 200) begin @(negedge CLK); w++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    m = model(v, s);
    e.res = m[31:0]; e.inex = m[32]; e.lat = exp_latency(v, s); e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial forever begin
    @(negedge CLK);
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial forever begin : monitor
    exp_t e;
    @(negedge CLK);
    #1;
    if (RESET) seen = 0;
    else if (out_valid) begin
      if (seen == 0) begin seen = 1; first = cyc; end
      if (out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", result, 32'hxxxxxxxx);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("inexact", {31'd0, inexact}, {31'd0, e.inex});
          if (e.lat < 0) chk("zero_latency_le1", {31'd0, (first - e.acc) <= 1}, 32'd1);
          else           chk("latency", first - e.acc, e.lat);
        end
        seen = 0;
      end
    end
  end

  logic [31:0] dir_v [9] = '{32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h01000001, 32'h01000003, 32'h0, 32'h0};
  logic        dir_s [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : main
    int w;
    int bad;
    logic [31:0] v;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);

    // Fixed-value sanity of the reference against hand-derived words.
    chk("model_one", model(32'h1, 1'b0), {1'b0, 32'h3F800000});
    chk("model_tie_up", model(32'h01000003, 1'b0), {1'b1, 32'h4B800002});

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(dir_v[i], dir_s[i]);

    // Backpressure: stall in DONE, offer a competing operand, then release.
    w = 0;
    while (!in_ready && w < 200) begin @(negedge CLK); w++; end
    out_ready = 1'b0;
    send(32'h01000003, 1'b0);
    w = 0;
    while (!out_valid && w < 100) begin @(negedge CLK); w++; end
    chk("stall_reach_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1; int_in = 32'h12345678; is_signed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("stall_result", result, 32'h4B800002);
      chk("stall_inexact", {31'd0, inexact}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    send(32'h12345678, 1'b0);

    // Reset mid-NORM aborts the operand silently.
    w = 0;
    while (!in_ready && w < 200) begin @(negedge CLK); w++; end
    in_valid = 1'b1; int_in = 32'h1; is_signed = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) bad++;
      @(negedge CLK);
    end
    chk("aborted_no_output", bad, 0);
    send(32'h3, 1'b0);

    // Randomized operands with random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = $urandom >> $urandom_range(0, 31);
        2: v = 32'd0;
        3: v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
        default: v = ~($urandom >> $urandom_range(0, 31));
      endcase
      send(v, 1'($urandom_range(0, 1)));
    end

    w = 0;
    while (sb.size() != 0 && w < 3000) begin @(negedge CLK); w++; end
    chk("drain_pending", sb.size(), 0);
    rnd_bp = 1'b0;
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
